// File: rtl/ghost_mover.sv
// ghost_mover: moves one ghost around the maze at a programmable tick rate.
// Before each step it asks the shared map lookup whether the neighbouring
// cell is a wall (valid/ready). It tries up to four candidate directions,
// chosen by mode (wander / chase / frightened / freeze), then either moves
// or reports that it is stuck.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   enable                 move attempts permitted
//   respawn                synchronous return to the initial position/direction
//   mode[1:0]              00 wander, 01 chase, 10 frightened, 11 freeze
//   target_x/target_y      chase target
//   wq_valid/wq_x/wq_y     wall query towards the map lookup
//   wq_ready/wq_wall       map answer (wq_wall sampled on valid & ready)
//   x/y/direction          ghost position and heading (00 up,01 right,10 down,11 left)
//   step                   one-cycle pulse when x/y change
//   stuck                  one-cycle pulse when all four candidates are walls
module ghost_mover #(
    parameter int            XW        = 10,
    parameter int            YW        = 9,
    parameter int            STEP      = 1,
    parameter int            TICK_DIV  = 4,
    parameter logic [XW-1:0] INIT_X    = 10'd100,
    parameter logic [YW-1:0] INIT_Y    = 9'd100,
    parameter logic [1:0]    INIT_DIR  = 2'b00,
    parameter logic [15:0]   LFSR_SEED = 16'hACE1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          respawn,
    input  logic [1:0]    mode,
    input  logic [XW-1:0] target_x,
    input  logic [YW-1:0] target_y,
    output logic          wq_valid,
    output logic [XW-1:0] wq_x,
    output logic [YW-1:0] wq_y,
    input  logic          wq_ready,
    input  logic          wq_wall,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [1:0]    direction,
    output logic          step,
    output logic          stuck
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
    localparam int AW = ((XW > YW) ? XW : YW) + 1;

    localparam logic [1:0] D_UP    = 2'd0;
    localparam logic [1:0] D_RIGHT = 2'd1;
    localparam logic [1:0] D_DOWN  = 2'd2;
    localparam logic [1:0] D_LEFT  = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_PROBE, S_MOVE} state_t;

    state_t              state_q;
    logic [XW-1:0]       x_q, wq_x_q;
    logic [YW-1:0]       y_q, wq_y_q;
    logic [1:0]          dir_q;
    logic                wq_valid_q, step_q, stuck_q;
    logic [CW-1:0]       cnt_q;
    logic [1:0]          idx_q;
    logic [3:0][1:0]     cand_q, cand_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [1:0]          mode_q;
    logic                fr_pend_q, fr_pend_d;

    logic                attempt_go, fr_first;
    logic [1:0]          base, w1, w2, x_dir, y_dir, prim, sec;
    logic [XW:0]         dx, adx;
    logic [YW:0]         dy, ady;

    assign wq_valid  = wq_valid_q;
    assign wq_x      = wq_x_q;
    assign wq_y      = wq_y_q;
    assign x         = x_q;
    assign y         = y_q;
    assign direction = dir_q;
    assign step      = step_q;
    assign stuck     = stuck_q;

    // Neighbour cell in direction d; wraps modulo 2^XW / 2^YW (tunnel).
    function automatic logic [XW+YW-1:0] nbr(input logic [1:0] d,
                                             input logic [XW-1:0] px,
                                             input logic [YW-1:0] py);
        logic [XW-1:0] nx;
        logic [YW-1:0] ny;
        nx = px;
        ny = py;
        case (d)
            D_UP:    ny = py - YW'(STEP);
            D_RIGHT: nx = px + XW'(STEP);
            D_DOWN:  ny = py + YW'(STEP);
            default: nx = px - XW'(STEP);
        endcase
        return {nx, ny};
    endfunction

    // Fibonacci LFSR, taps 16,14,13,11, shifting towards bit 0.
    assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    assign attempt_go = (state_q == S_IDLE) && enable && (mode != 2'b11) &&
                        (cnt_q == CNT_LAST);

    // Frightened reversal applies once: from the cycle mode becomes 10 until
    // the next attempt latches its candidate list.
    assign fr_first  = (mode == 2'b10) && (fr_pend_q || (mode_q != 2'b10));
    assign fr_pend_d = fr_first && !attempt_go;

    always_comb begin
        base  = fr_first ? dir_q + 2'd2 : dir_q;
        w1    = lfsr_q[0] ? base + 2'd3 : base + 2'd1;
        w2    = lfsr_q[0] ? base + 2'd1 : base + 2'd3;

        dx    = {1'b0, target_x} - {1'b0, x_q};
        dy    = {1'b0, target_y} - {1'b0, y_q};
        adx   = dx[XW] ? -dx : dx;
        ady   = dy[YW] ? -dy : dy;
        x_dir = dx[XW] ? D_LEFT : D_RIGHT;
        y_dir = dy[YW] ? D_UP : D_DOWN;

        // Tie goes to the x axis; with no offset at all keep heading.
        if (AW'(adx) >= AW'(ady)) begin
            prim = (dx == '0) ? dir_q : x_dir;
            sec  = (dy == '0) ? w1 : y_dir;
        end else begin
            prim = y_dir;
            sec  = (dx == '0) ? w1 : x_dir;
        end

        cand_d[0] = base;
        cand_d[1] = w1;
        cand_d[2] = w2;
        cand_d[3] = base + 2'd2;
        if (mode == 2'b01) begin
            cand_d[0] = prim;
            cand_d[1] = sec;
            cand_d[2] = dir_q;
            cand_d[3] = dir_q + 2'd2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            x_q        <= INIT_X;
            y_q        <= INIT_Y;
            dir_q      <= INIT_DIR;
            wq_valid_q <= 1'b0;
            wq_x_q     <= '0;
            wq_y_q     <= '0;
            step_q     <= 1'b0;
            stuck_q    <= 1'b0;
            cnt_q      <= '0;
            idx_q      <= '0;
            cand_q     <= '0;
            lfsr_q     <= LFSR_SEED;
            mode_q     <= 2'b00;
            fr_pend_q  <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            step_q  <= 1'b0;
            stuck_q <= 1'b0;
            if (respawn) begin
                state_q    <= S_IDLE;
                x_q        <= INIT_X;
                y_q        <= INIT_Y;
                dir_q      <= INIT_DIR;
                wq_valid_q <= 1'b0;
                cnt_q      <= '0;
                idx_q      <= '0;
                mode_q     <= 2'b00;
                fr_pend_q  <= 1'b0;
            end else begin
                mode_q    <= mode;
                fr_pend_q <= fr_pend_d;
                case (state_q)
                    S_IDLE: begin
                        if (enable && mode != 2'b11) begin
                            if (attempt_go) begin
                                cnt_q              <= '0;
                                idx_q              <= '0;
                                cand_q             <= cand_d;
                                {wq_x_q, wq_y_q}   <= nbr(cand_d[0], x_q, y_q);
                                wq_valid_q         <= 1'b1;
                                state_q            <= S_PROBE;
                            end else begin
                                cnt_q <= cnt_q + CW'(1);
                            end
                        end
                    end
                    S_PROBE: begin
                        if (wq_ready) begin
                            if (!wq_wall) begin
                                wq_valid_q <= 1'b0;
                                state_q    <= S_MOVE;
                            end else if (idx_q != 2'd3) begin
                                idx_q            <= idx_q + 2'd1;
                                {wq_x_q, wq_y_q} <= nbr(cand_q[idx_q + 2'd1], x_q, y_q);
                            end else begin
                                wq_valid_q <= 1'b0;
                                stuck_q    <= 1'b1;
                                state_q    <= S_IDLE;
                            end
                        end
                    end
                    S_MOVE: begin
                        x_q     <= wq_x_q;
                        y_q     <= wq_y_q;
                        dir_q   <= cand_q[idx_q];
                        step_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ghost_mover.sv
// Scoreboard bench for ghost_mover: expected wall queries and steps are queued
// as stimulus is set up and compared as the DUT issues them.
module tb_ghost_mover;

    localparam int XW = 10;
    localparam int YW = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          respawn = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [XW-1:0] target_x = '0;
    logic [YW-1:0] target_y = '0;
    logic          wq_valid;
    logic [XW-1:0] wq_x;
    logic [YW-1:0] wq_y;
    logic          wq_ready = 1'b0;
    logic          wq_wall = 1'b0;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [1:0]    direction;
    logic          step;
    logic          stuck;

    always #5 clk = ~clk;

    ghost_mover dut (
        .clk(clk), .rst(rst), .enable(enable), .respawn(respawn), .mode(mode),
        .target_x(target_x), .target_y(target_y),
        .wq_valid(wq_valid), .wq_x(wq_x), .wq_y(wq_y),
        .wq_ready(wq_ready), .wq_wall(wq_wall),
        .x(x), .y(y), .direction(direction), .step(step), .stuck(stuck)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [18:0] a;
        logic [18:0] b;
        bit          diff;
    } qexp_t;

    qexp_t       q_exp[$];
    logic [20:0] s_exp[$];

    function automatic logic [18:0] xy(input int px, input int py);
        return {XW'(px), YW'(py)};
    endfunction

    task automatic push_q(input int px, input int py);
        qexp_t e;
        e.a = xy(px, py); e.b = e.a; e.diff = 1'b0;
        q_exp.push_back(e);
    endtask

    // Either of two cells; diff demands it differs from the previous probe.
    task automatic push_alt(input int ax, input int ay, input int bx, input int by, input bit d);
        qexp_t e;
        e.a = xy(ax, ay); e.b = xy(bx, by); e.diff = d;
        q_exp.push_back(e);
    endtask

    task automatic push_s(input int d, input int px, input int py);
        s_exp.push_back({2'(d), xy(px, py)});
    endtask

    // Map model: up to four wall cells.
    logic [18:0] wall_c[4];
    logic [3:0]  wall_v = '0;

    function automatic bit is_wall(input logic [18:0] c);
        for (int i = 0; i < 4; i++)
            if (wall_v[i] && wall_c[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    task automatic set_wall(input int i, input int px, input int py);
        wall_c[i] = xy(px, py);
        wall_v[i] = 1'b1;
    endtask

    always @(negedge clk) wq_wall <= is_wall({wq_x, wq_y});

    // Monitor
    int          cyc = 0;
    int          last_probe_cyc = 0;
    int          last_step_cyc = -1;
    int          stuck_cyc = -1;
    int          n_stuck = 0;
    bit          prev_valid = 1'b0;
    bit          prev_stuck = 1'b0;
    bit          per_chk = 1'b0;
    bit          gap_chk = 1'b0;
    logic [18:0] prev_probe = '0;
    logic [18:0] mo;
    logic [20:0] so;
    qexp_t       me;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (wq_valid && wq_ready) begin
                mo = {wq_x, wq_y};
                if (gap_chk && !prev_valid && stuck_cyc >= 0)
                    chk("stuck_gap", cyc - stuck_cyc, 4);
                if (q_exp.size() == 0) begin
                    chk("q_unexpected", q_exp.size(), 1);
                end else begin
                    me = q_exp.pop_front();
                    chk("wq_xy", mo, (mo === me.b) ? me.b : me.a);
                    if (me.diff) chk("perp_order", mo != prev_probe, 1);
                end
                prev_probe = mo;
                last_probe_cyc = cyc;
            end
            if (step) begin
                so = {direction, x, y};
                if (s_exp.size() == 0) chk("s_unexpected", s_exp.size(), 1);
                else chk("step_dxy", so, s_exp.pop_front());
                chk("probe_to_step", cyc - last_probe_cyc, 2);
                if (per_chk && last_step_cyc >= 0) chk("step_period", cyc - last_step_cyc, 6);
                last_step_cyc = cyc;
            end
            if (stuck) begin
                chk("stuck_width", prev_stuck, 0);
                n_stuck++;
                stuck_cyc = cyc;
            end
            prev_valid = wq_valid;
            prev_stuck = stuck;
        end
    end

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while ((q_exp.size() != 0 || s_exp.size() != 0) && n < maxc) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain", q_exp.size() + s_exp.size(), 0);
    endtask

    task automatic do_respawn();
        @(negedge clk); #1 respawn = 1'b1;
        @(negedge clk); #1 respawn = 1'b0;
    endtask

    task automatic wait_valid(input int maxc);
        int n;
        n = 0;
        while (!wq_valid && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("valid_seen", wq_valid, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nv;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_x", x, 100);
        chk("rst_y", y, 100);
        chk("rst_dir", direction, 0);
        chk("rst_wq_valid", wq_valid, 0);
        chk("rst_step", step, 0);
        chk("rst_stuck", stuck, 0);
        #1 rst = 1'b0; wq_ready = 1'b1; mode = 2'b00; enable = 1'b1;

        // Open map, wander up: step every 6 clocks
        per_chk = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            push_q(100, 100 - k);
            push_s(0, 100, 100 - k);
        end
        drain(100);
        per_chk = 1'b0;
        enable = 1'b0;

        // Up and both sides walled, down open
        set_wall(0, 100, 99); set_wall(1, 99, 100); set_wall(2, 101, 100);
        do_respawn();
        enable = 1'b1;
        push_q(100, 99);
        push_alt(99, 100, 101, 100, 1'b0);
        push_alt(99, 100, 101, 100, 1'b1);
        push_q(100, 101);
        push_s(2, 100, 101);
        drain(100);
        enable = 1'b0;

        // Boxed in: stuck twice, TICK_DIV apart
        set_wall(3, 100, 101);
        do_respawn();
        gap_chk = 1'b1;
        enable = 1'b1;
        for (int a = 0; a < 2; a++) begin
            push_q(100, 99);
            push_alt(99, 100, 101, 100, 1'b0);
            push_alt(99, 100, 101, 100, 1'b1);
            push_q(100, 101);
        end
        drain(100);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        gap_chk = 1'b0;
        chk("stuck_count", n_stuck, 2);
        chk("stuck_xyd", {direction, x, y}, {2'd0, xy(100, 100)});

        // Chase
        wall_v = '0;
        do_respawn();
        mode = 2'b01; target_x = 130; target_y = 105;
        enable = 1'b1;
        push_q(101, 100); push_s(1, 101, 100);
        drain(100);
        enable = 1'b0;
        target_x = 100; target_y = 60;
        enable = 1'b1;
        push_q(101, 99); push_s(0, 101, 99);
        drain(100);
        enable = 1'b0;

        // Face right, then wander across the right edge
        do_respawn();
        target_x = 130; target_y = 100;
        enable = 1'b1;
        push_q(101, 100); push_s(1, 101, 100);
        drain(100);
        enable = 1'b0;
        mode = 2'b00;
        enable = 1'b1;
        for (int xx = 102; xx <= 1024; xx++) begin
            push_q(xx % 1024, 100);
            push_s(1, xx % 1024, 100);
        end
        drain(7000);
        enable = 1'b0;

        // Frightened: first attempt reverses, then wander
        mode = 2'b10;
        enable = 1'b1;
        push_q(1023, 100); push_s(3, 1023, 100);
        push_q(1022, 100); push_s(3, 1022, 100);
        drain(100);
        enable = 1'b0;

        // Freeze: no queries
        do_respawn();
        mode = 2'b11;
        enable = 1'b1;
        nv = 0;
        repeat (20) begin
            @(negedge clk);
            if (wq_valid) nv++;
        end
        chk("freeze_no_query", nv, 0);

        // Stalled query then respawn
        mode = 2'b00;
        push_q(100, 99); push_s(0, 100, 99);
        drain(100);
        wq_ready = 1'b0;
        wait_valid(50);
        nv = 0;
        repeat (10) begin
            @(negedge clk);
            if ({wq_valid, wq_x, wq_y} !== {1'b1, xy(100, 98)}) nv++;
        end
        chk("stall_hold", nv, 0);
        #1 respawn = 1'b1;
        @(negedge clk);
        chk("respawn_valid", wq_valid, 0);
        chk("respawn_xyd", {direction, x, y}, {2'd0, xy(100, 100)});
        #1 respawn = 1'b0;

        // Async reset mid-probe
        wq_ready = 1'b1;
        push_q(100, 99); push_s(0, 100, 99);
        drain(100);
        wq_ready = 1'b0;
        wait_valid(50);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", wq_valid, 0);
        chk("arst_xyd", {direction, x, y}, {2'd0, xy(100, 100)});
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/ghost_mover.md
Name: ghost_mover

Overview:
- Parametrised successor to the single-ghost movement block. Moves one ghost over the maze at a programmable tick rate.
- Before every step it queries the map for walls through a valid/ready handshake.
- Selects a direction according to a mode: wander, chase, frightened or freeze.
- Sits between the game-state controller and the shared map lookup. Its x, y and direction outputs drive the sprite renderer.

Parameters:
- XW, 10, x coordinate width
- YW, 9, y coordinate width
- STEP, 1, pixels moved per successful step
- TICK_DIV, 4, clocks spent in IDLE between move attempts (>=1)
- INIT_X, 10'd100, x after reset/respawn
- INIT_Y, 9'd100, y after reset/respawn
- INIT_DIR, 2'b00, direction after reset/respawn
- LFSR_SEED, 16'hACE1, LFSR reset value (nonzero)

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  asynchronous, active-high reset
- enable  in  1  move attempts permitted when high
- respawn  in  1  synchronous return to initial state
- mode  in  2  00 wander, 01 chase, 10 frightened, 11 freeze
- target_x  in  XW  chase target x
- target_y  in  YW  chase target y
- wq_valid  out  1  wall query request
- wq_x  out  XW  queried cell x
- wq_y  out  YW  queried cell y
- wq_ready  in  1  map answer valid this cycle
- wq_wall  in  1  1 = queried cell is wall (sampled when wq_valid&wq_ready)
- x  out  XW  ghost x
- y  out  YW  ghost y
- direction  out  2  00 up, 01 right, 10 down, 11 left
- step  out  1  one-cycle pulse on the cycle x/y change
- stuck  out  1  one-cycle pulse when all 4 candidates are walls

Behaviour:

Reset (rst high, asynchronous):
- x=INIT_X, y=INIT_Y, direction=INIT_DIR.
- wq_valid=0, step=0, stuck=0.
- Tick counter=0, candidate index=0, LFSR=LFSR_SEED, FSM=IDLE.

Respawn:
- Synchronous and highest priority below rst. Produces the same values as reset except the LFSR, which keeps running.
- Aborts any pending query; wq_valid is 0 on the next cycle.

LFSR:
- 16-bit Fibonacci, taps 16,14,13,11. Advances every clock.
- r = bit0.

FSM:
- IDLE: if enable and mode!=11, the counter increments each clock. When counter==TICK_DIV-1:
  - build the candidate list c0..c3 for the current mode,
  - clear counter and index,
  - go to PROBE.
  - In mode 11, or with enable low, the counter holds.
- PROBE: wq_valid=1. wq_x/wq_y = position offset by STEP in direction c[idx]:
  - up: y-STEP; down: y+STEP; right: x+STEP; left: x-STEP.
  - Arithmetic is modulo 2^XW / 2^YW, so the screen edge wraps (tunnel).
  - wq_valid, wq_x and wq_y stay stable until wq_ready.
  - On wq_ready with wq_wall=0: go to MOVE.
  - On wq_ready with wq_wall=1 and idx<3: idx++, stay in PROBE; wq_valid stays high with new coordinates next cycle.
  - On wq_ready with wq_wall=1 and idx==3: pulse stuck, go to IDLE; x, y and direction unchanged.
- MOVE: one cycle.
  - x/y take the probed coordinates, direction=c[idx], step=1.
  - wq_valid=0. Return to IDLE.

Candidate lists (latched at attempt start; p=perpendicular, rev=reverse of direction):
- Wander (00): c0=direction; c1=(r ? direction+3 : direction+1); c2=other perpendicular; c3=rev.
- Chase (01):
  - dx=target_x-x, dy=target_y-y, signed.
  - Primary axis = larger |d|; tie means x axis.
  - c0=primary toward target; c1=secondary toward target (if the secondary d=0, use the wander c1).
  - c2=direction; c3=rev.
  - Duplicates are probed again, which is harmless.
- Frightened (10): on the first attempt after mode changes to 10, c0=rev and the rest follow wander order relative to rev. Afterwards identical to wander.

Timing and mode changes:
- Minimum attempt latency with wq_ready tied high: TICK_DIV + 2 clocks from leaving IDLE count start to the step pulse.
- A mode change mid-attempt does not alter the latched list.
- A target change mid-attempt is ignored.

Test Plan:
- Reset then open map, mode 00, dir 00, TICK_DIV=4, wq_ready tied 1 -> y: 100->99 with a step pulse every 6 clocks; x=100; one query per step at (100,99).
- Up wall, both perpendiculars wall, down clear -> 4 probes in order; direction=10, y=101 after the 4th probe answer +1 clock.
- All four neighbours walls -> stuck pulses once; x, y and direction unchanged; next attempt after TICK_DIV.
- Chase, ghost (100,100), target (130,105), open map -> direction=01, x=101; target (100,60) -> direction=00.
- x=1023 facing right, open map -> x=0 after step; wq_x=0 during the probe.
- wq_ready held low 10 cycles, then respawn -> wq_valid 0 next clock, state back to init; async rst pulse mid-PROBE -> outputs at reset values immediately, without waiting for a clock.
